// File: rtl/sample_fifo.sv
// sample_fifo: circular sample buffer between the sample source and the DSP filter
// stages. It has a registered single-cycle pop, occupancy flags and a synchronous flush.
// An optional prime gate holds reads off until the buffer has been full once since the
// last reset or flush.
module sample_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
  parameter int PRIME_MODE = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  primed
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam bit                GATE_RD = (PRIME_MODE != 0);

  // Storage is deliberately left unreset; the pointers and count define what is valid.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  rd_ok;
  logic                  wr_ok;

  // Flags come straight from the registered count, so they carry no extra latency.
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF_C);

  // A pop needs data, and when gating is enabled the buffer must have been primed.
  // A write into a full buffer is accepted only when a pop frees a slot in the same cycle.
  // Flush overrides both, so nothing moves while the buffer is being cleared.
  assign rd_ok = rd_en & ~flush & ~empty & (primed | ~GATE_RD);
  assign wr_ok = wr_en & ~flush & (~full | rd_ok);

  // Next occupancy. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + ONE_C;
      2'b01:   count_nxt = count - ONE_C;
      default: count_nxt = count;
    endcase
  end

  // ---- stage p0 -> p1: the sample array captures accepted writes ----
  // Write into the array at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Update pointers, count and the sticky primed flag; flush returns them to the empty state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      primed <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      primed <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      if (count_nxt == DEPTH_C) begin
        primed <= 1'b1;
      end
    end
  end

  // ---- stage p1: registered read port ----
  // Register the popped head. The array read happens before this edge's write lands, so a
  // same-cycle push is never bypassed. Data is held at zero whenever it is not valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_ok) begin
      rd_valid <= 1'b1;
      rd_data  <= mem[rd_ptr];
    end else begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end
  end

endmodule
